blink_ctrl: RTL
===============

# blink_ctrl

Parametrised multi-LED status controller for board bring-up designs. A free-running counter drives NUM_LEDS outputs in one of four display modes: blink, chase, breathe (triangle PWM) or off. A debounced push-button cycles through the modes. Sits directly behind the board clock buffer and drives LED pins or output buffers.

## Interface
- CNT_WIDTH, 27: free-running counter width; sets blink period 2^CNT_WIDTH cycles; legal range ≥ PWM_WIDTH+3
- NUM_LEDS, 4: number of LED outputs; ≥ 2
- PWM_WIDTH, 8: breathe duty resolution in bits; ≥ 1
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level; ≥ 2
- clk  in  1  sole clock; all state is on its rising edge
- rst_n  in  1  reset, asynchronous, active-low; the integrator provides deassertion synchronous to clk
- button  in  1  raw asynchronous push-button, active-high
- leds  out  NUM_LEDS  registered LED drive, active-high
- button_led  out  1  registered debounced button level
- mode  out  2  current display mode: 0 BLINK, 1 CHASE, 2 BREATHE, 3 OFF

## Operation
- Reset clears the following state: r_count=0, mode=BLINK, pos=0, leds=0, button_led=0, both synchroniser flops=0, debounce counter=0.
- r_count increments every cycle and wraps from all-ones to 0.
- Button path:
  - Two-flop synchroniser produces btn_s.
  - Debounce counter resets to 0 whenever btn_s equals the debounced level. Otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and btn_s still differs, the debounced level (button_led) takes btn_s and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES leaves button_led unchanged.
- Mode FSM: BLINK→CHASE→BREATHE→OFF→BLINK.
  - Advances only on a 0→1 transition of the debounced level, on the same edge that button_led rises.
  - Release has no effect.
- Chase tick: r_count[CNT_WIDTH-2:0] is all-ones.
  - On each tick, pos advances by 1. It wraps from NUM_LEDS-1 to 0.
  - pos runs in every mode. It is not cleared on a mode change.
- LED function, evaluated on current r_count/pos/mode and registered into leds:
  - BLINK: all bits = r_count[CNT_WIDTH-1].
  - CHASE: one-hot, bit pos set.
  - BREATHE:
    - phase = r_count[CNT_WIDTH-1 -: PWM_WIDTH+1].
    - duty = phase MSB ? ~phase[PWM_WIDTH-1:0] : phase[PWM_WIDTH-1:0].
    - All bits = (r_count[PWM_WIDTH-1:0] < duty), unsigned compare.
    - duty=0 means always off. The maximum duty gives (2^PWM_WIDTH-1)/2^PWM_WIDTH on-time.
  - OFF: all 0.
- Reset asserted mid-operation (including during a debounce count) abandons all state immediately. No mode advance occurs for a press in progress.

## Timing
- leds lag r_count by exactly 1 cycle (single output register). There is no combinational path from input to output.
- Button latency: a raw edge held stable is reflected on button_led 2 (synchroniser) + DEBOUNCE_CYCLES cycles after the first clk edge that samples it. mode changes on that same edge.
- The first leds value for a new mode appears 1 cycle after mode updates.
- A tick coinciding with a mode change: pos still advances. CHASE entered on that edge uses the new pos.

## Structure
- Package blink_pkg holds:
  - mode_t (2-bit enum MODE_BLINK/CHASE/BREATHE/OFF)
  - clog2-derived width constant helpers
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES) contains the synchroniser plus debounce counter. It outputs the level and a one-cycle rise pulse.
- Top level holds r_count, pos, the mode FSM and the LED output register.

## Test plan
All scenarios run with CNT_WIDTH=8, PWM_WIDTH=2, DEBOUNCE_CYCLES=4, NUM_LEDS=4.
- Reset release, no button → leds=0000 for 129 cycles, then 1111 for 128, alternating; mode=0; button_led=0.
- button high 3 cycles then low → button_led stays 0, mode stays 0. Held high → button_led=1 and mode=1 exactly 6 cycles after the first sampling edge.
- CHASE → leds step 0001→0010→0100→1000→0001, one step per 128 cycles, each step 1 cycle after r_count[6:0]=127.
- BREATHE → r_count[7:5]=0..7 gives duty 0,1,2,3,3,2,1,0. leds on-count per 4-cycle window equals duty: all off when phase is 0 or 7, 3 of 4 cycles when phase is 3 or 4.
- Fourth press → mode=3, leds=0000 one cycle later. Fifth press → mode=0, blink resumes.
- rst_n pulsed low while button held 2 cycles into debounce → all outputs 0 immediately. With button still high after release, button_led and mode=1 arrive 6 cycles later.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg: shared types and helpers for the blink_ctrl LED status controller.
//   mode_t     - display mode encoding (matches the 2-bit mode output)
//   idx_width  - bits needed to index 0..n-1 (minimum 1)
//   next_mode  - mode sequence BLINK -> CHASE -> BREATHE -> OFF -> BLINK
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK   = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    // Width of a counter/index holding 0..n-1; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t nm;
        case (m)
            MODE_BLINK:   nm = MODE_CHASE;
            MODE_CHASE:   nm = MODE_BREATHE;
            MODE_BREATHE: nm = MODE_OFF;
            default:      nm = MODE_BLINK;
        endcase
        return nm;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser plus stability counter for a raw push-button.
//   clk      - clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   btn_i    - raw asynchronous button, active-high
//   level_o  - registered debounced level
//   rise_o   - high in the cycle whose clock edge raises level_o (one cycle wide)
module button_debounce
    import blink_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned    DbW    = idx_width(DEBOUNCE_CYCLES);
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DbW-1:0] DbOne  = DbW'(1);

    logic           sync1_q, sync2_q;
    logic           level_q, level_d;
    logic [DbW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive cycles the synchronised input disagrees with the accepted level;
    // any agreement restarts the count, so short glitches never get through.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_o  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == DbLast) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_o  = sync2_q;
        end else begin
            cnt_d = cnt_q + DbOne;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/blink_ctrl.sv
// blink_ctrl: multi-LED status controller (blink / chase / breathe / off).
//   clk         - sole clock, rising edge
//   rst_n       - asynchronous active-low reset
//   button      - raw push-button, active-high; each debounced press advances the mode
//   leds        - registered LED drive, active-high
//   button_led  - registered debounced button level
//   mode        - current display mode (0 blink, 1 chase, 2 breathe, 3 off)
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = 27,
    parameter int unsigned NUM_LEDS        = 4,
    parameter int unsigned PWM_WIDTH       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                button,
    output logic [NUM_LEDS-1:0] leds,
    output logic                button_led,
    output logic [1:0]          mode
);

    localparam int unsigned          PosW    = idx_width(NUM_LEDS);
    localparam logic [PosW-1:0]      PosLast = PosW'(NUM_LEDS - 1);
    localparam logic [PosW-1:0]      PosOne  = PosW'(1);
    localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [PosW-1:0]      pos_q, pos_d;
    mode_t                mode_q, mode_d;
    logic [NUM_LEDS-1:0]  leds_q, leds_d;

    logic                 btn_rise;
    logic                 chase_tick;
    logic [PWM_WIDTH:0]   phase;
    logic [PWM_WIDTH-1:0] duty;
    logic                 pwm_on;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (button),
        .level_o (button_led),
        .rise_o  (btn_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            pos_q   <= '0;
            mode_q  <= MODE_BLINK;
            leds_q  <= '0;
        end else begin
            count_q <= count_d;
            pos_q   <= pos_d;
            mode_q  <= mode_d;
            leds_q  <= leds_d;
        end
    end

    // Counter, chase position and mode sequencing. pos keeps running in every mode.
    always_comb begin
        chase_tick = &count_q[CNT_WIDTH-2:0];
        count_d    = count_q + CntOne;
        pos_d      = pos_q;
        if (chase_tick) begin
            pos_d = (pos_q == PosLast) ? '0 : pos_q + PosOne;
        end
        mode_d = btn_rise ? next_mode(mode_q) : mode_q;
    end

    // LED pattern from the current (pre-edge) counter, position and mode.
    always_comb begin
        // Triangle duty: ramps up over the first half of the phase window, down over the second.
        phase  = count_q[CNT_WIDTH-1 -: PWM_WIDTH+1];
        duty   = phase[PWM_WIDTH] ? ~phase[PWM_WIDTH-1:0] : phase[PWM_WIDTH-1:0];
        pwm_on = count_q[PWM_WIDTH-1:0] < duty;
        leds_d = '0;
        unique case (mode_q)
            MODE_BLINK:   leds_d = {NUM_LEDS{count_q[CNT_WIDTH-1]}};
            MODE_CHASE:   leds_d[pos_q] = 1'b1;
            MODE_BREATHE: leds_d = {NUM_LEDS{pwm_on}};
            MODE_OFF:     leds_d = '0;
            default:      leds_d = '0;
        endcase
    end

    assign leds = leds_q;
    assign mode = mode_q;

endmodule
